// File: rtl/module_keypad_encoder.sv
// module_keypad_encoder: 4x4 matrix keypad scanner with press/release debounce and hex encoding.
// Optional auto-repeat while a key is held: define KEYPAD_AUTOREPEAT_EN.
module module_keypad_encoder #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int BW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_CYCLES - 1);

    if (SCAN_DIV < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("module_keypad_encoder: illegal parameter value");
    end

    typedef enum logic [1:0] {SCAN, DEB_PRESS, PRESSED, DEB_RELEASE} state_t;

    state_t        state;
    logic [DW-1:0] div_cnt;
    logic [BW-1:0] deb_cnt;
    logic [1:0]    col_idx;
    logic [1:0]    row_idx;
    logic [1:0]    nxt_idx;
    logic [1:0]    low_row;
    logic          tracked_low;

    // Lowest-numbered active row wins when several rows read low together.
    assign low_row     = !row[0] ? 2'd0 : !row[1] ? 2'd1 : !row[2] ? 2'd2 : 2'd3;
    assign nxt_idx     = col_idx + 2'd1;
    assign tracked_low = !row[row_idx];

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0] rep_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCAN;
            div_cnt   <= '0;
            deb_cnt   <= '0;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            col       <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else if (row != 4'hF) begin
                        row_idx <= low_row;
                        deb_cnt <= '0;
                        state   <= DEB_PRESS;
                    end else begin
                        div_cnt <= '0;
                        col_idx <= nxt_idx;
                        col     <= ~(4'b0001 << nxt_idx);
                    end
                end
                DEB_PRESS: begin
                    if (!tracked_low) begin
                        state   <= SCAN;
                        div_cnt <= '0;
                        col_idx <= nxt_idx;
                        col     <= ~(4'b0001 << nxt_idx);
                    end else if (deb_cnt == DEB_LAST) begin
                        key_code  <= {row_idx, col_idx};
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state     <= PRESSED;
`ifdef KEYPAD_AUTOREPEAT_EN
                        rep_cnt   <= '0;
`endif
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!tracked_low) begin
                        deb_cnt <= '0;
                        state   <= DEB_RELEASE;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_cnt == REP_LAST) begin
                        key_valid <= 1'b1;
                        rep_cnt   <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    if (tracked_low) begin
                        state <= PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        key_held <= 1'b0;
                        state    <= SCAN;
                        div_cnt  <= '0;
                        col_idx  <= nxt_idx;
                        col      <= ~(4'b0001 << nxt_idx);
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule
